model_convolutional_fnn_layer: RTL and testbench

- Parametrised successor to the convolutional FNN controller constants: a sequential fixed-point 1D valid-convolution layer.
- Computes H[j] = B + sum_{k=0}^{SIZE_W-1} W[k]*X[j+k] for j = 0 .. SIZE_X-SIZE_W.
- Runtime lengths; kernel and input buffered on-chip; one MAC per cycle; output stream with backpressure.
- Sits in the NTM controller datapath between the input vector source and the controller output stage.

---
 rtl/model_convolutional_fnn_layer.sv | 223 ++++++++++++++++++++++
 tb/tb_model_convolutional_fnn_layer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_convolutional_fnn_layer.sv
// Sequential fixed-point 1D valid convolution: H[j] = B + sum W[k]*X[j+k].
// Define CONVOLUTIONAL_FNN_SATURATION_EN to saturate outputs instead of wrapping.
module model_convolutional_fnn_layer #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 32,
  parameter int MAX_X         = 64,
  parameter int MAX_W         = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    ERROR,
  input  logic [CONTROL_SIZE-1:0] SIZE_X_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0]    B_IN,
  input  logic                    W_IN_ENABLE,
  output logic                    W_ENABLE,
  input  logic [DATA_SIZE-1:0]    W_IN,
  input  logic                    X_IN_ENABLE,
  output logic                    X_ENABLE,
  input  logic [DATA_SIZE-1:0]    X_IN,
  output logic                    H_OUT_ENABLE,
  input  logic                    H_OUT_READY,
  output logic [DATA_SIZE-1:0]    H_OUT
);

  localparam int ACC_W = 2*DATA_SIZE + $clog2(MAX_W) + 1;
  localparam int XW    = $clog2(MAX_X + 1);
  localparam int WW    = $clog2(MAX_W + 1);
  localparam int XI    = (MAX_X > 1) ? $clog2(MAX_X) : 1;
  localparam int WI    = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_X  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0]              r_state;
  logic [WW-1:0]           r_sw;
  logic [WW-1:0]           r_k;
  logic [XW-1:0]           r_sx;
  logic [XW-1:0]           r_cnt;
  logic [XW-1:0]           r_j;
  logic [DATA_SIZE-1:0]    r_bias;
  logic [DATA_SIZE-1:0]    r_hout;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_prime;
  logic                    r_ready;
  logic                    r_error;

  logic [DATA_SIZE-1:0] r_wbuf [MAX_W];
  logic [DATA_SIZE-1:0] r_xbuf [MAX_X];

  logic                      w_err;
  logic                      w_w_acc;
  logic                      w_x_acc;
  logic                      w_w_last;
  logic                      w_x_last;
  logic                      w_k_last;
  logic                      w_j_more;
  logic [XI-1:0]             w_xi;
  logic [DATA_SIZE-1:0]      w_wd;
  logic [DATA_SIZE-1:0]      w_xd;
  logic signed [2*DATA_SIZE-1:0] w_we;
  logic signed [2*DATA_SIZE-1:0] w_xe;
  logic signed [2*DATA_SIZE-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_bias_ext;
  logic [DATA_SIZE-1:0]      w_res;

  assign w_err = (SIZE_W_IN == '0)
              || (SIZE_W_IN > CONTROL_SIZE'(MAX_W))
              || (SIZE_X_IN > CONTROL_SIZE'(MAX_X))
              || (SIZE_W_IN > SIZE_X_IN);

  assign w_w_acc  = (r_state == S_LOAD_W) && W_IN_ENABLE;
  assign w_x_acc  = (r_state == S_LOAD_X) && X_IN_ENABLE;
  assign w_w_last = r_cnt == XW'(r_sw) - XW'(1);
  assign w_x_last = r_cnt == r_sx - XW'(1);
  assign w_k_last = r_k == r_sw - WW'(1);
  assign w_j_more = r_j < (r_sx - XW'(r_sw));

  assign w_xi = XI'(r_j) + XI'(r_k);
  assign w_wd = r_wbuf[r_k[WI-1:0]];
  assign w_xd = r_xbuf[w_xi];

  assign w_we   = {{DATA_SIZE{w_wd[DATA_SIZE-1]}}, w_wd};
  assign w_xe   = {{DATA_SIZE{w_xd[DATA_SIZE-1]}}, w_xd};
  assign w_prod = w_we * w_xe;

  assign w_prod_ext = {{(ACC_W-2*DATA_SIZE){w_prod[2*DATA_SIZE-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_bias_ext = {{(ACC_W-DATA_SIZE){r_bias[DATA_SIZE-1]}}, r_bias}
                      << FRACTION_SIZE;

`ifdef CONVOLUTIONAL_FNN_SATURATION_EN
  localparam logic signed [ACC_W-1:0] P_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = w_sum >>> FRACTION_SIZE;

  always_comb begin
    w_res = w_shift[DATA_SIZE-1:0];
    if (w_shift > P_MAX)
      w_res = {1'b0, {(DATA_SIZE-1){1'b1}}};
    else if (w_shift < P_MIN)
      w_res = {1'b1, {(DATA_SIZE-1){1'b0}}};
  end
`else
  assign w_res = DATA_SIZE'(w_sum >>> FRACTION_SIZE);
`endif

  assign READY        = r_ready;
  assign ERROR        = r_error;
  assign W_ENABLE     = r_state == S_LOAD_W;
  assign X_ENABLE     = r_state == S_LOAD_X;
  assign H_OUT_ENABLE = r_state == S_OUTPUT;
  assign H_OUT        = r_hout;

  always_ff @(posedge CLK) begin
    if (w_w_acc)
      r_wbuf[r_cnt[WI-1:0]] <= W_IN;
    if (w_x_acc)
      r_xbuf[r_cnt[XI-1:0]] <= X_IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_sw    <= '0;
      r_k     <= '0;
      r_sx    <= '0;
      r_cnt   <= '0;
      r_j     <= '0;
      r_bias  <= '0;
      r_hout  <= '0;
      r_acc   <= '0;
      r_prime <= 1'b0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            r_bias <= B_IN;
            r_sw   <= SIZE_W_IN[WW-1:0];
            r_sx   <= SIZE_X_IN[XW-1:0];
            r_cnt  <= '0;
            if (w_err) begin
              r_ready <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state <= S_LOAD_W;
            end
          end
        end
        S_LOAD_W: begin
          if (W_IN_ENABLE) begin
            if (w_w_last) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_X;
            end else begin
              r_cnt <= r_cnt + XW'(1);
            end
          end
        end
        S_LOAD_X: begin
          if (X_IN_ENABLE) begin
            if (w_x_last) begin
              r_cnt   <= '0;
              r_j     <= '0;
              r_k     <= '0;
              r_prime <= 1'b1;
              r_state <= S_COMPUTE;
            end else begin
              r_cnt <= r_cnt + XW'(1);
            end
          end
        end
        S_COMPUTE: begin
          // First entry spends one cycle seeding the accumulator with the bias
          if (r_prime) begin
            r_prime <= 1'b0;
            r_acc   <= w_bias_ext;
          end else begin
            r_acc <= w_sum;
            if (w_k_last) begin
              r_k     <= '0;
              r_hout  <= w_res;
              r_state <= S_OUTPUT;
            end else begin
              r_k <= r_k + WW'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (H_OUT_READY) begin
            if (w_j_more) begin
              r_j     <= r_j + XW'(1);
              r_acc   <= w_bias_ext;
              r_state <= S_COMPUTE;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_convolutional_fnn_layer.sv
// Randomized self-checking bench for model_convolutional_fnn_layer.
// Honours CONVOLUTIONAL_FNN_SATURATION_EN when choosing expected overflow results.
module tb_model_convolutional_fnn_layer;

  localparam int D  = 16;
  localparam int C  = 32;
  localparam int F  = 0;
  localparam int MX = 16;
  localparam int MW = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         READY;
  logic         ERROR;
  logic [C-1:0] SIZE_X_IN;
  logic [C-1:0] SIZE_W_IN;
  logic [D-1:0] B_IN;
  logic         W_IN_ENABLE;
  logic         W_ENABLE;
  logic [D-1:0] W_IN;
  logic         X_IN_ENABLE;
  logic         X_ENABLE;
  logic [D-1:0] X_IN;
  logic         H_OUT_ENABLE;
  logic         H_OUT_READY;
  logic [D-1:0] H_OUT;

  model_convolutional_fnn_layer #(
    .DATA_SIZE(D), .CONTROL_SIZE(C), .FRACTION_SIZE(F),
    .MAX_X(MX), .MAX_W(MW)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
    .SIZE_X_IN(SIZE_X_IN), .SIZE_W_IN(SIZE_W_IN), .B_IN(B_IN),
    .W_IN_ENABLE(W_IN_ENABLE), .W_ENABLE(W_ENABLE), .W_IN(W_IN),
    .X_IN_ENABLE(X_IN_ENABLE), .X_ENABLE(X_ENABLE), .X_IN(X_IN),
    .H_OUT_ENABLE(H_OUT_ENABLE), .H_OUT_READY(H_OUT_READY), .H_OUT(H_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] got_h[$];
  int           hs_cyc[$];
  int           lastx_cyc;
  int           first_en_cyc;
  int           ready_cyc;
  logic         ready_error;
  int           excl_bad;
  int           unstable;
  int           any_en;
  logic         ready_width_bad;
  logic         timeout;

  logic [D-1:0] w_q[$];
  logic [D-1:0] x_q[$];

  function automatic logic [D-1:0] ref_h(input logic [D-1:0] b,
                                         input logic [D-1:0] wv[$],
                                         input logic [D-1:0] xv[$],
                                         input int j);
    longint acc;
    acc = longint'($signed(b)) <<< F;
    for (int k = 0; k < wv.size(); k++)
      acc += longint'($signed(wv[k])) * longint'($signed(xv[j+k]));
    acc = acc >>> F;
`ifdef CONVOLUTIONAL_FNN_SATURATION_EN
    if (acc > 64'sd32767) return 16'h7FFF;
    if (acc < -64'sd32768) return 16'h8000;
`endif
    return acc[D-1:0];
  endfunction

  task automatic idle_inputs();
    START       = 1'b0;
    W_IN_ENABLE = 1'b0;
    X_IN_ENABLE = 1'b0;
    H_OUT_READY = 1'b0;
  endtask

  // Drives one operation; records observations for the calling scenario.
  task automatic run_conv(input int sw, input int sx, input logic [D-1:0] b,
                          input int gap_pct, input int rdy_pct,
                          input int hold0, input int abort_after);
    int n = 0;
    int wi = 0;
    int xi = 0;
    int held = 0;
    logic prev_en = 1'b0;
    logic [D-1:0] prev_h = '0;
    got_h.delete();
    hs_cyc.delete();
    lastx_cyc = -1; first_en_cyc = -1; ready_cyc = -1;
    ready_error = 1'b0; excl_bad = 0; unstable = 0; any_en = 0;
    ready_width_bad = 1'b0; timeout = 1'b0;
    @(negedge CLK);
    START = 1'b1; SIZE_W_IN = C'(sw); SIZE_X_IN = C'(sx); B_IN = b;
    W_IN_ENABLE = 1'b0; X_IN_ENABLE = 1'b0; H_OUT_READY = 1'b0;
    forever begin
      @(negedge CLK);
      n++;
      if (READY) begin
        ready_cyc = n;
        ready_error = ERROR;
        break;
      end
      if (abort_after >= 0 && lastx_cyc >= 0 && n == lastx_cyc + abort_after) begin
        idle_inputs();
        return;
      end
      if (int'(W_ENABLE) + int'(X_ENABLE) + int'(H_OUT_ENABLE) > 1) excl_bad++;
      if (W_ENABLE || X_ENABLE || H_OUT_ENABLE) any_en++;
      START = ($urandom_range(0, 9) == 0);
      SIZE_W_IN = $urandom; SIZE_X_IN = $urandom; B_IN = $urandom;
      if (W_ENABLE && wi < sw && $urandom_range(0, 99) >= gap_pct) begin
        W_IN_ENABLE = 1'b1; W_IN = w_q[wi]; wi++;
      end else begin
        W_IN_ENABLE = W_ENABLE ? 1'b0 : 1'($urandom_range(0, 1));
        W_IN = $urandom;
      end
      if (X_ENABLE && xi < sx && $urandom_range(0, 99) >= gap_pct) begin
        X_IN_ENABLE = 1'b1; X_IN = x_q[xi]; xi++;
        if (xi == sx) lastx_cyc = n;
      end else begin
        X_IN_ENABLE = X_ENABLE ? 1'b0 : 1'($urandom_range(0, 1));
        X_IN = $urandom;
      end
      if (H_OUT_ENABLE) begin
        if (first_en_cyc < 0) first_en_cyc = n;
        if (prev_en && H_OUT !== prev_h) unstable++;
        if (got_h.size() == 0 && held < hold0) begin
          H_OUT_READY = 1'b0; held++;
        end else begin
          H_OUT_READY = ($urandom_range(0, 99) < rdy_pct);
        end
        if (H_OUT_READY) begin
          got_h.push_back(H_OUT); hs_cyc.push_back(n); prev_en = 1'b0;
        end else begin
          prev_en = 1'b1; prev_h = H_OUT;
        end
      end else begin
        H_OUT_READY = 1'($urandom_range(0, 1));
        prev_en = 1'b0;
      end
      if (n > 3000) begin
        timeout = 1'b1;
        break;
      end
    end
    idle_inputs();
    if (!timeout) begin
      @(negedge CLK);
      ready_width_bad = READY;
    end
  endtask

  task automatic load_basic(input int b);
    w_q = '{16'd1, 16'd2, 16'd1};
    x_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    run_conv(3, 5, D'(b), 0, 100, 0, -1);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    SIZE_W_IN = '0; SIZE_X_IN = '0; B_IN = '0; W_IN = '0; X_IN = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({READY, ERROR, W_ENABLE, X_ENABLE, H_OUT_ENABLE} !== 5'b0 || H_OUT !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b h=%0d exp 00000 h=0",
               {READY, ERROR, W_ENABLE, X_ENABLE, H_OUT_ENABLE}, H_OUT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [D-1:0] exp_h[3];
    exp_h = '{16'd8, 16'd12, 16'd16};
    load_basic(0);
    checks++;
    if (timeout || got_h.size() != 3) begin
      errors++;
      $display("FAIL basic_count got %0d exp 3 timeout=%0b", got_h.size(), timeout);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_h[i] !== exp_h[i]) begin
        errors++;
        $display("FAIL basic_h[%0d] got %0d exp %0d", i, got_h[i], exp_h[i]);
      end
    end
    checks++;
    if (first_en_cyc - lastx_cyc !== 5) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 5 negedges",
               first_en_cyc - lastx_cyc);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (hs_cyc[i] - hs_cyc[i-1] !== 4) begin
        errors++;
        $display("FAIL basic_spacing[%0d] got %0d exp 4", i, hs_cyc[i] - hs_cyc[i-1]);
      end
    end
    checks++;
    if (ready_cyc - hs_cyc[2] !== 1 || ready_error !== 1'b0 || ready_width_bad !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready got dist=%0d err=%0b width_bad=%0b exp 1 0 0",
               ready_cyc - hs_cyc[2], ready_error, ready_width_bad);
    end
    checks++;
    if (excl_bad !== 0) begin
      errors++;
      $display("FAIL basic_exclusive got %0d overlaps exp 0", excl_bad);
    end
  endtask

  task automatic test_bias();
    logic [D-1:0] exp_h[3];
    exp_h = '{16'd18, 16'd22, 16'd26};
    load_basic(10);
    checks++;
    if (timeout || got_h.size() != 3) begin
      errors++;
      $display("FAIL bias_count got %0d exp 3", got_h.size());
      return;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_h[i] !== exp_h[i]) begin
        errors++;
        $display("FAIL bias_h[%0d] got %0d exp %0d", i, got_h[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_error();
    int sws[5];
    int sxs[5];
    sws = '{4, 0, MW + 1, 2, MW};
    sxs = '{3, 5, MX, MX + 1, MW - 1};
    w_q = '{}; x_q = '{};
    for (int i = 0; i < 5; i++) begin
      run_conv(sws[i], sxs[i], 16'd0, 0, 100, 0, -1);
      checks++;
      if (ready_cyc !== 1 || ready_error !== 1'b1 || any_en !== 0 || ready_width_bad !== 1'b0) begin
        errors++;
        $display("FAIL error[%0d] got ready_at=%0d err=%0b en=%0d exp 1 1 0",
                 i, ready_cyc, ready_error, any_en);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [D-1:0] exp_h[3];
    exp_h = '{16'd8, 16'd12, 16'd16};
    w_q = '{16'd1, 16'd2, 16'd1};
    x_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    run_conv(3, 5, 16'd0, 0, 100, 5, -1);
    checks++;
    if (timeout || got_h.size() != 3) begin
      errors++;
      $display("FAIL bp_count got %0d exp 3", got_h.size());
      return;
    end
    checks++;
    if (unstable !== 0 || got_h[0] !== exp_h[0]) begin
      errors++;
      $display("FAIL bp_hold got unstable=%0d h=%0d exp 0 8", unstable, got_h[0]);
    end
    checks++;
    if (hs_cyc[0] - first_en_cyc !== 5 || hs_cyc[1] - hs_cyc[0] !== 4) begin
      errors++;
      $display("FAIL bp_timing got wait=%0d next=%0d exp 5 4",
               hs_cyc[0] - first_en_cyc, hs_cyc[1] - hs_cyc[0]);
    end
    checks++;
    if (got_h[1] !== exp_h[1] || got_h[2] !== exp_h[2]) begin
      errors++;
      $display("FAIL bp_tail got %0d %0d exp 12 16", got_h[1], got_h[2]);
    end
  endtask

  task automatic test_overflow();
    logic [D-1:0] exp_v;
`ifdef CONVOLUTIONAL_FNN_SATURATION_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'hFFFC;
`endif
    w_q = '{16'd32767, 16'd32767};
    x_q = '{16'd2, 16'd2};
    run_conv(2, 2, 16'd0, 0, 100, 0, -1);
    checks++;
    if (timeout || got_h.size() != 1 || got_h[0] !== exp_v) begin
      errors++;
      $display("FAIL overflow got n=%0d h=%h exp n=1 h=%h",
               got_h.size(), got_h.size() ? got_h[0] : 16'h0, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    int ready_seen = 0;
    w_q = '{16'd1, 16'd2, 16'd1};
    x_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    run_conv(3, 5, 16'd0, 0, 100, 0, 3);
    RST = 1'b1;
    #1;
    checks++;
    if ({READY, ERROR, W_ENABLE, X_ENABLE, H_OUT_ENABLE} !== 5'b0 || H_OUT !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b h=%0d exp 00000 h=0",
               {READY, ERROR, W_ENABLE, X_ENABLE, H_OUT_ENABLE}, H_OUT);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (READY || H_OUT_ENABLE) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active cycles exp 0", ready_seen);
    end
    load_basic(0);
    checks++;
    if (got_h.size() != 3 || got_h[0] !== 16'd8 || got_h[1] !== 16'd12 || got_h[2] !== 16'd16) begin
      errors++;
      $display("FAIL reset_mid_rerun got n=%0d exp 8,12,16", got_h.size());
    end
  endtask

  task automatic test_random();
    int sw;
    int sx;
    logic [D-1:0] b;
    logic [D-1:0] e;
    for (int it = 0; it < 30; it++) begin
      if (it == 0) begin sw = MW; sx = MX; end
      else if (it == 1) begin sw = 5; sx = 5; end
      else if (it == 2) begin sw = 1; sx = 1; end
      else begin
        sw = $urandom_range(1, MW);
        sx = $urandom_range(sw, MX);
      end
      b = $urandom;
      w_q = '{}; x_q = '{};
      for (int k = 0; k < sw; k++) w_q.push_back(D'($urandom));
      for (int k = 0; k < sx; k++) x_q.push_back(D'($urandom));
      run_conv(sw, sx, b, 30, 60, 0, -1);
      checks++;
      if (timeout || got_h.size() != sx - sw + 1 || ready_error !== 1'b0 || excl_bad !== 0) begin
        errors++;
        $display("FAIL rand[%0d]_count got %0d exp %0d timeout=%0b err=%0b excl=%0d",
                 it, got_h.size(), sx - sw + 1, timeout, ready_error, excl_bad);
        continue;
      end
      for (int j = 0; j <= sx - sw; j++) begin
        e = ref_h(b, w_q, x_q, j);
        checks++;
        if (got_h[j] !== e) begin
          errors++;
          $display("FAIL rand[%0d]_h[%0d] got %h exp %h", it, j, got_h[j], e);
        end
      end
      checks++;
      if (unstable !== 0) begin
        errors++;
        $display("FAIL rand[%0d]_stable got %0d changes exp 0", it, unstable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_error();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
